// File: rtl/status_value_vector_pkg.sv
// Shared types and helpers for the status value vector family:
// default sizes, width derivations, the {pull,push} op encoding and the
// per-slot next-value select.
package status_value_vector_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    // Occupancy count width: must represent 0..depth inclusive.
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Age-index width: addresses slots 0..depth-1.
    function automatic int iw_of(input int depth);
        return $clog2(depth);
    endfunction

    // Encoding of {pull, push}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_PULL = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    // Next-value source for one storage slot.
    typedef enum logic [2:0] {
        SEL_HOLD  = 3'd0,
        SEL_SHIFT = 3'd1,
        SEL_LOAD  = 3'd2,
        SEL_UPD   = 3'd3,
        SEL_CLEAR = 3'd4
    } sel_e;

endpackage

// File: rtl/status_value_slot.sv
// One storage slot of the status value vector: picks its next value from
// hold, the slot above (shift toward head), the pushed value, the update
// value, or zero.
module status_value_slot
    import status_value_vector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  sel_e             sel_i,
    input  logic [WIDTH-1:0] shift_i,
    input  logic [WIDTH-1:0] load_i,
    input  logic [WIDTH-1:0] upd_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next-value mux.
    always_comb begin
        value_d = value_q;
        unique case (sel_i)
            SEL_SHIFT: value_d = shift_i;
            SEL_LOAD:  value_d = load_i;
            SEL_UPD:   value_d = upd_i;
            SEL_CLEAR: value_d = '0;
            default:   value_d = value_q;
        endcase
    end

    // Slot register; reset empties the slot so freed slots read 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/status_value_vector_idx.sv
// In-order shift-register queue of status entries with occupancy count,
// almost-full flag, overflow/underflow pulses and indexed update of live
// entries. Indexed update is built only when STATUS_VALUE_VECTOR_IDX_UPD_EN
// is defined; otherwise the update ports are ignored and upd_err_o is 0.
module status_value_vector_idx
    import status_value_vector_pkg::*;
#(
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int AFULL_TH = DEPTH - 2,
    localparam int CW       = cw_of(DEPTH),
    localparam int IW       = iw_of(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             pull_i,
    input  logic             upd_i,
    input  logic [IW-1:0]    upd_idx_i,
    input  logic [WIDTH-1:0] upd_value_i,
    output logic [WIDTH-1:0] value_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             afull_o,
    output logic [CW-1:0]    count_o,
    output logic             ovf_o,
    output logic             unf_o,
    output logic             upd_err_o
);

    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             err_q, err_d;

    logic             empty, full;
    logic             do_push, do_shift;
    logic [CW-1:0]    wr_pos;
    logic             upd_hit;
    logic [CW-1:0]    upd_tgt;
    logic [WIDTH-1:0] upd_val;
    op_e              op;

    sel_e             sel   [DEPTH];
    logic [WIDTH-1:0] slot_v[DEPTH];

    assign op    = op_e'({pull_i, push_i});
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Decode push/pull into shift/append actions and error pulses.
    always_comb begin
        do_push  = 1'b0;
        do_shift = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        unique case (op)
            OP_PUSH: begin
                if (full) ovf_d   = 1'b1;
                else      do_push = 1'b1;
            end
            OP_PULL: begin
                if (empty) unf_d    = 1'b1;
                else       do_shift = 1'b1;
            end
            OP_BOTH: begin
                // On empty the pull is ignored and the push lands in slot 0.
                do_push  = 1'b1;
                do_shift = !empty;
            end
            default: ;
        endcase
    end

    // Append position accounts for a same-cycle shift.
    assign wr_pos = do_shift ? (count_q - CW'(1)) : count_q;

`ifdef STATUS_VALUE_VECTOR_IDX_UPD_EN
    logic upd_ok;
    // Index is relative to pre-cycle positions; it follows a same-cycle shift,
    // and an update of the retiring head is dropped without error.
    always_comb begin
        upd_ok  = upd_i && (CW'(upd_idx_i) < count_q);
        err_d   = upd_i && !upd_ok;
        upd_tgt = do_shift ? (CW'(upd_idx_i) - CW'(1)) : CW'(upd_idx_i);
        upd_hit = upd_ok && !(do_shift && (upd_idx_i == '0));
    end
    assign upd_val = upd_value_i;
`else
    logic unused_upd;
    assign unused_upd = ^{upd_i, upd_idx_i, upd_value_i};
    assign err_d      = 1'b0;
    assign upd_tgt    = '0;
    assign upd_hit    = 1'b0;
    assign upd_val    = '0;
`endif

    // Per-slot select: shift baseline, then update, then append (never collide).
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            sel[k] = SEL_HOLD;
            if (do_shift) sel[k] = (k == DEPTH - 1) ? SEL_CLEAR : SEL_SHIFT;
            if (upd_hit && (upd_tgt == CW'(k))) sel[k] = SEL_UPD;
            if (do_push && (wr_pos == CW'(k))) sel[k] = SEL_LOAD;
        end
    end

    // Next occupancy and its thermometer-coded valid vector.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_shift) count_d = count_q + CW'(1);
        if (do_shift && !do_push) count_d = count_q - CW'(1);
        for (int k = 0; k < DEPTH; k++) begin
            valid_d[k] = (CW'(k) < count_d);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [WIDTH-1:0] shift_src;
        if (g == DEPTH - 1) begin : g_top
            assign shift_src = '0;
        end else begin : g_mid
            assign shift_src = slot_v[g+1];
        end
        status_value_slot #(.WIDTH(WIDTH)) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .sel_i   (sel[g]),
            .shift_i (shift_src),
            .load_i  (value_i),
            .upd_i   (upd_val),
            .value_o (slot_v[g])
        );
    end

    // Control state: count, valid vector and one-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    assign value_o   = slot_v[0];
    assign valid_o   = valid_q[0];
    assign full_o    = valid_q[DEPTH-1];
    assign afull_o   = valid_q[AFULL_TH-1];
    assign count_o   = count_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;
    assign upd_err_o = err_q;

endmodule

// File: doc/status_value_vector_idx.md
# status_value_vector_idx

Parametrised successor to the status value vector: an in-order shift-register queue of WIDTH-bit status entries, up to DEPTH deep. Adds an occupancy count, an almost-full flag, overflow/underflow pulses, and random-access update of any live entry by its age index. Sits between a producer that posts status entries and a consumer that retires them oldest-first, while a third agent can patch in-flight entries.

## Interface
- DEPTH, 16, number of entries (≥2)
- WIDTH, 8, bits per entry
- AFULL_TH, DEPTH-2, count at or above which afull_o asserts (1..DEPTH)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)
- IW, $clog2(DEPTH), index width (derived, not overridden)

- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- push_i  in  1  append value_i at tail
- value_i  in  WIDTH  entry to append
- pull_i  in  1  retire head entry
- upd_i  in  1  overwrite entry at upd_idx_i
- upd_idx_i  in  IW  age index; 0 = oldest (head)
- upd_value_i  in  WIDTH  replacement value
- value_o  out  WIDTH  head entry
- valid_o  out  1  head entry valid (count_o ≠ 0)
- full_o  out  1  count_o == DEPTH
- afull_o  out  1  count_o ≥ AFULL_TH
- count_o  out  CW  live entries
- ovf_o  out  1  one-cycle pulse: push dropped
- unf_o  out  1  one-cycle pulse: pull on empty
- upd_err_o  out  1  one-cycle pulse: update rejected

## Operation
- Storage: DEPTH slots, slot 0 = head; live entries contiguous in slots 0..count-1; valid bit per slot, thermometer-coded.
- Push only, not full: write value_i to slot count; count+1.
- Push only, full: no change; ovf_o pulses.
- Pull only, non-empty: all slots shift toward 0; top slot cleared to 0; count-1.
- Pull only, empty: no change; unf_o pulses.
- Push+pull, non-empty (incl. full): shift, value_i written to slot count-1; count unchanged; no ovf.
- Push+pull, empty: value_i stored in slot 0, pull ignored, count=1; no unf (no bypass).
- Update: upd_idx_i refers to pre-cycle positions. Legal when upd_idx_i < count_o; entry takes upd_value_i and moves with any simultaneous shift (lands in slot idx-1 on pull).
- Update of idx 0 with simultaneous pull: entry retires unchanged; update dropped silently (not an error).
- Update with upd_idx_i ≥ count_o (including the slot a same-cycle push fills): ignored; upd_err_o pulses.
- Freed slots always hold 0.

## Timing
- All outputs registered or decoded from registers only; no input-to-output combinational path.
- Effect of any operation visible on outputs the cycle after the sampling edge; push to empty gives valid_o=1 and value_o=value_i one cycle later.
- Pulses (ovf_o, unf_o, upd_err_o) high exactly one cycle after the offending edge.
- Reset: all slots 0, count_o=0, valid_o=0, value_o=0, full_o=0, afull_o=0, all pulses 0; reset dominates all inputs in the same cycle; reset mid-operation discards every entry.

## Configuration
- STATUS_VALUE_VECTOR_IDX_UPD_EN defined: indexed update as above.
- Not defined: update logic removed; upd_i, upd_idx_i, upd_value_i ignored; upd_err_o tied 0; ports remain.

## Structure
- Shared package/header status_value_vector_pkg: CW/IW clog2 derivation, default DEPTH/WIDTH constants, op encoding of {pull,push} (IDLE, PUSH, PULL, BOTH).
- Sub-module status_value_slot: per-slot next-value mux (hold / shift-in from slot+1 / load value_i / load upd_value_i / clear), instanced DEPTH times via generate; top holds count, valid vector, flags.

## Test plan
- Reset, push 0x11,0x22,0x33, pull ×3 -> value_o 0x11,0x22,0x33 in order; count 3→0; valid_o 0 after last; 4th pull -> unf_o one pulse.
- DEPTH=4: push 4 -> full_o=1, count 4; 5th push -> ovf_o pulse, contents unchanged; push+pull 0x55 -> head retires, 0x55 at tail, full_o stays 1.
- Empty, push+pull 0xA5 same cycle -> count 1, value_o 0xA5, no unf_o.
- Three entries, update idx 1 to 0xEE with pull -> next cycle value_o 0xEE, count 2; update idx 3 -> upd_err_o pulse, no change.
- AFULL_TH=3: count crosses 2→3 -> afull_o 1; pull to 2 -> afull_o 0.
- Assert rst_i mid-stream with push high -> all outputs 0 next cycle; macro undefined build -> updates have no effect, upd_err_o always 0.
